// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter and its load scoreboard.
package wb_arbiter_pkg;
  localparam int REG_W     = 5;
  localparam int NUM_REGS  = 32;
  localparam int MAXLD_DEF = 4;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t RA_IDX   = 5'd31;
  localparam reg_idx_t ZERO_IDX = 5'd0;

  // Which request owns the register-file write port this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2
  } wb_src_e;

  // JAL always links into the return-address register
  function automatic reg_idx_t alu_dest(input reg_idx_t rd, input logic jal);
    return jal ? RA_IDX : rd;
  endfunction
endpackage

// File: rtl/load_scoreboard.sv
// Tracks outstanding loads: per-register pending bits plus an in-flight count.
module load_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int MAXLD = MAXLD_DEF
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     issue,
  input  reg_idx_t issue_rd,
  output logic     issue_ready,
  input  logic     ret_valid,
  input  reg_idx_t ret_rd,
  output logic     ret_ok,
  input  reg_idx_t alu_rd,
  output logic     alu_busy,
  input  reg_idx_t rr1,
  input  reg_idx_t rr2,
  output logic     hazard
);
  localparam int CW = $clog2(MAXLD + 1);

  logic [NUM_REGS-1:0] pending, pend_eff, pend_nxt;
  logic [CW-1:0]       cnt, cnt_eff, cnt_nxt;
  logic                issue_fire;

  // While reset is held every lookup sees an empty scoreboard
  assign pend_eff = reset ? '0 : pending;
  assign cnt_eff  = reset ? '0 : cnt;

  assign issue_ready = (cnt_eff < CW'(MAXLD)) &&
                       ((issue_rd == ZERO_IDX) || !pend_eff[issue_rd]);
  assign issue_fire  = issue && issue_ready;
  // A return with nothing in flight is bogus and is dropped entirely
  assign ret_ok      = ret_valid && (cnt_eff != '0);
  assign alu_busy    = pend_eff[alu_rd];
  assign hazard      = pend_eff[rr1] | pend_eff[rr2];

  // Clear on return first, then set on issue so an equal-rd issue wins
  always_comb begin
    pend_nxt = pending;
    cnt_nxt  = cnt;
    if (ret_ok) begin
      pend_nxt[ret_rd] = 1'b0;
      cnt_nxt          = cnt_nxt - CW'(1);
    end
    if (issue_fire) begin
      pend_nxt[issue_rd] = 1'b1;
      cnt_nxt            = cnt_nxt + CW'(1);
    end
    pend_nxt[ZERO_IDX] = 1'b0;
  end

  // Scoreboard state register
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      pending <= pend_nxt;
      cnt     <= cnt_nxt;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: load returns beat ALU results, one
// registered write per cycle. The register file's jal_ra input is tied 0
// because JAL is resolved here by steering the destination to r31.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int W     = 32,
  parameter int MAXLD = MAXLD_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [REG_W-1:0] alu_rd,
  input  logic             alu_jal,
  input  logic [W-1:0]     alu_data,
  output logic             alu_ready,
  input  logic             ld_issue,
  input  logic [REG_W-1:0] ld_issue_rd,
  output logic             ld_issue_ready,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [W-1:0]     mem_data,
  input  logic [REG_W-1:0] rr1_in,
  input  logic [REG_W-1:0] rr2_in,
  output logic             rd_hazard,
  output logic             regwrite,
  output logic [REG_W-1:0] wr_out,
  output logic [W-1:0]     write_data_out
);
  reg_idx_t       adest;
  logic           alu_busy, mem_ok;
  wb_src_e        src;
  reg_idx_t       win_rd;
  logic [W-1:0]   win_data;

  assign adest = alu_dest(alu_rd, alu_jal);

  load_scoreboard #(.MAXLD(MAXLD)) u_sb (
    .clock       (clock),
    .reset       (reset),
    .issue       (ld_issue),
    .issue_rd    (ld_issue_rd),
    .issue_ready (ld_issue_ready),
    .ret_valid   (mem_valid),
    .ret_rd      (mem_rd),
    .ret_ok      (mem_ok),
    .alu_rd      (adest),
    .alu_busy    (alu_busy),
    .rr1         (rr1_in),
    .rr2         (rr2_in),
    .hazard      (rd_hazard)
  );

  // Memory cannot stall, so any mem_valid blocks the ALU; a pending load on
  // the ALU destination also blocks it to keep write-after-write order
  assign alu_ready = alu_valid && !mem_valid && !alu_busy;

  // Pick the winner for this cycle
  always_comb begin
    src      = SRC_NONE;
    win_rd   = ZERO_IDX;
    win_data = '0;
    if (mem_ok) begin
      src      = SRC_MEM;
      win_rd   = mem_rd;
      win_data = mem_data;
    end else if (alu_ready) begin
      src      = SRC_ALU;
      win_rd   = adest;
      win_data = alu_data;
    end
  end

  // Write port register; idle cycles keep the last address/data
  always_ff @(posedge clock) begin
    if (reset) begin
      regwrite       <= 1'b0;
      wr_out         <= '0;
      write_data_out <= '0;
    end else begin
      regwrite <= (src != SRC_NONE) && (win_rd != ZERO_IDX);
      if (src != SRC_NONE) begin
        wr_out         <= win_rd;
        write_data_out <= win_data;
      end
    end
  end
endmodule
